// File: rtl/seg_add_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: one SEG-bit ripple segment per stage,
// carry registered between stages, valid/ready handshakes on input and output.
module seg_add_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);
  localparam int STAGES = WIDTH / SEG;

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // One global enable: the whole pipe moves together or freezes together.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign b_eff    = sub ? ~b : b;
  assign c_eff    = sub ? 1'b1 : ci;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    localparam int REM_W  = WIDTH - i * SEG;
    localparam int DONE_W = (i + 1) * SEG;

    logic [REM_W-1:0]  rem_a;
    logic [REM_W-1:0]  rem_b;
    logic              c_in;
    logic              v_in;
    logic [SEG-1:0]    seg_s;
    logic [SEG:0]      carries;
    logic [DONE_W-1:0] sum_in;
    logic [DONE_W-1:0] sum_q;
    logic              carry_q;
    logic              valid_q;

    // rem_a/rem_b hold the operand segments not yet consumed; bit 0 is this stage's segment.
    if (i == 0) begin : g_head
      assign rem_a  = a;
      assign rem_b  = b_eff;
      assign c_in   = c_eff;
      assign v_in   = in_valid;
      assign sum_in = seg_s;
    end else begin : g_body
      assign rem_a  = g_stage[i-1].g_fwd.a_q;
      assign rem_b  = g_stage[i-1].g_fwd.b_q;
      assign c_in   = g_stage[i-1].carry_q;
      assign v_in   = g_stage[i-1].valid_q;
      assign sum_in = {seg_s, g_stage[i-1].sum_q};
    end

    always_comb begin
      carries[0] = c_in;
      seg_s      = '0;
      for (int j = 0; j < SEG; j++) begin
        seg_s[j]     = rem_a[j] ^ rem_b[j] ^ carries[j];
        carries[j+1] = (rem_a[j] & rem_b[j]) | (carries[j] & (rem_a[j] ^ rem_b[j]));
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (en) begin
        valid_q <= v_in;
        carry_q <= carries[SEG];
        sum_q   <= sum_in;
      end
    end

    if (i < STAGES - 1) begin : g_fwd
      logic [REM_W-SEG-1:0] a_q;
      logic [REM_W-SEG-1:0] b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= rem_a[REM_W-1:SEG];
          b_q <= rem_b[REM_W-1:SEG];
        end
      end
    end else begin : g_last
      logic ovf_q;

      // Overflow is carry into the MSB xor carry out of it, both known only here.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= carries[SEG-1] ^ carries[SEG];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign s         = g_stage[STAGES-1].sum_q;
  assign co        = g_stage[STAGES-1].carry_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule
